// File: rtl/score_keeper.sv
// Score, combo and max-combo accumulator fed by the arrow judgement stage,
// plus a frame-timed display latch for the last grade shown on the HUD.
module score_keeper #(
    parameter int SCORE_W        = 16,
    parameter int COMBO_W        = 8,
    parameter int MARV_PTS       = 10,
    parameter int PERF_PTS       = 8,
    parameter int GREAT_PTS      = 5,
    parameter int GOOD_PTS       = 2,
    parameter int COMBO_BONUS_TH = 10,
    parameter int HOLD_FRAMES    = 30
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               frame_i,
    input  logic [3:0]         judge_i,
    input  logic               miss_i,
    output logic [SCORE_W-1:0] score_o,
    output logic [COMBO_W-1:0] combo_o,
    output logic [COMBO_W-1:0] max_combo_o,
    output logic [2:0]         grade_o,
    output logic               grade_valid_o
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    typedef logic [SCORE_W:0]  pts_t;
    typedef logic [HOLD_W-1:0] hold_t;
    typedef enum logic { IDLE, SHOW } state_t;

    localparam logic [2:0] GRADE_NONE  = 3'd0;
    localparam logic [2:0] GRADE_GOOD  = 3'd1;
    localparam logic [2:0] GRADE_GREAT = 3'd2;
    localparam logic [2:0] GRADE_PERF  = 3'd3;
    localparam logic [2:0] GRADE_MARV  = 3'd4;
    localparam logic [2:0] GRADE_MISS  = 3'd5;

    // Sum is formed one bit wider than the score so a carry-out clamps instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input pts_t b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + b;
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [COMBO_W-1:0] sat_inc(input logic [COMBO_W-1:0] a);
        return (a == '1) ? a : a + 1'b1;
    endfunction

    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [COMBO_W-1:0] max_combo_q, max_combo_d;
    logic [2:0]         grade_q, grade_d;
    state_t             state_q, state_d;
    hold_t              hold_q, hold_d;

    logic               hit;
    logic               evt;
    logic [2:0]         hit_grade;
    pts_t               base_pts;
    pts_t               pts;
    logic [COMBO_W-1:0] combo_n;

    always_comb begin
        hit       = |judge_i;
        evt       = hit | miss_i;
        hit_grade = GRADE_NONE;
        base_pts  = '0;
        if (judge_i[3]) begin
            hit_grade = GRADE_MARV;
            base_pts  = pts_t'(MARV_PTS);
        end else if (judge_i[2]) begin
            hit_grade = GRADE_PERF;
            base_pts  = pts_t'(PERF_PTS);
        end else if (judge_i[1]) begin
            hit_grade = GRADE_GREAT;
            base_pts  = pts_t'(GREAT_PTS);
        end else if (judge_i[0]) begin
            hit_grade = GRADE_GOOD;
            base_pts  = pts_t'(GOOD_PTS);
        end
        combo_n = sat_inc(combo_q);
        pts     = (32'(combo_n) >= COMBO_BONUS_TH) ? (base_pts << 1) : base_pts;

        score_d     = score_q;
        combo_d     = combo_q;
        max_combo_d = max_combo_q;
        grade_d     = grade_q;
        state_d     = state_q;
        hold_d      = hold_q;

        // A simultaneous miss still scores the hit, then breaks the combo.
        if (hit) begin
            score_d = sat_add(score_q, pts);
            combo_d = miss_i ? '0 : combo_n;
            if (combo_n > max_combo_q) max_combo_d = combo_n;
        end else if (miss_i) begin
            combo_d = '0;
        end

        if (evt) begin
            state_d = SHOW;
            grade_d = hit ? hit_grade : GRADE_MISS;
            hold_d  = hold_t'(HOLD_FRAMES);
        end else if (state_q == SHOW && frame_i) begin
            if (hold_q == hold_t'(1)) begin
                state_d = IDLE;
                grade_d = GRADE_NONE;
                hold_d  = '0;
            end else begin
                hold_d = hold_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            grade_q     <= GRADE_NONE;
            state_q     <= IDLE;
            hold_q      <= '0;
        end else begin
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
            grade_q     <= grade_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
        end
    end

    assign score_o       = score_q;
    assign combo_o       = combo_q;
    assign max_combo_o   = max_combo_q;
    assign grade_o       = grade_q;
    assign grade_valid_o = (state_q == SHOW);

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: a default-width instance and a narrow (6-bit score,
// 3-bit combo) instance share the same stimulus and are tracked by an integer model.
module tb_score_keeper;

    localparam int HOLD = 30;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       frame_i = 1'b0;
    logic [3:0] judge_i = 4'd0;
    logic       miss_i = 1'b0;

    logic [15:0] score_w;
    logic [7:0]  combo_w, max_w;
    logic [2:0]  grade_w;
    logic        valid_w;
    logic [5:0]  score_s;
    logic [2:0]  combo_s, max_s;
    logic [2:0]  grade_s;
    logic        valid_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    score_keeper u_dut (
        .clk_i(clk), .reset_i(reset_i), .frame_i(frame_i), .judge_i(judge_i), .miss_i(miss_i),
        .score_o(score_w), .combo_o(combo_w), .max_combo_o(max_w),
        .grade_o(grade_w), .grade_valid_o(valid_w)
    );

    score_keeper #(.SCORE_W(6), .COMBO_W(3)) u_small (
        .clk_i(clk), .reset_i(reset_i), .frame_i(frame_i), .judge_i(judge_i), .miss_i(miss_i),
        .score_o(score_s), .combo_o(combo_s), .max_combo_o(max_s),
        .grade_o(grade_s), .grade_valid_o(valid_s)
    );

    typedef struct {
        int score;
        int combo;
        int mx;
        int grade;
        int left;
    } mstate_t;

    mstate_t mw = '{0, 0, 0, 0, 0};
    mstate_t ms = '{0, 0, 0, 0, 0};

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic [3:0] j, input bit m,
                                           input bit f, input int smax, input int cmax);
        mstate_t r;
        int pts, c, g;
        r = s;
        g = 0;
        if (j != 0) begin
            if (j[3])      begin pts = 10; g = 4; end
            else if (j[2]) begin pts = 8;  g = 3; end
            else if (j[1]) begin pts = 5;  g = 2; end
            else           begin pts = 2;  g = 1; end
            c = min2(s.combo + 1, cmax);
            if (c >= 10) pts = pts * 2;
            r.score = min2(s.score + pts, smax);
            if (c > r.mx) r.mx = c;
            r.combo = m ? 0 : c;
        end else if (m) begin
            r.combo = 0;
            g = 5;
        end
        if (j != 0 || m) begin
            r.grade = g;
            r.left  = HOLD;
        end else if (f && s.left > 0) begin
            r.left = s.left - 1;
            if (r.left == 0) r.grade = 0;
        end
        return r;
    endfunction

    task automatic compare_all(input string tag);
        check_val({tag, "_score"}, int'(score_w), mw.score);
        check_val({tag, "_combo"}, int'(combo_w), mw.combo);
        check_val({tag, "_max"},   int'(max_w),   mw.mx);
        check_val({tag, "_grade"}, int'(grade_w), mw.grade);
        check_val({tag, "_valid"}, int'(valid_w), (mw.left > 0) ? 1 : 0);
        check_val({tag, "_s_score"}, int'(score_s), ms.score);
        check_val({tag, "_s_combo"}, int'(combo_s), ms.combo);
        check_val({tag, "_s_max"},   int'(max_s),   ms.mx);
        check_val({tag, "_s_grade"}, int'(grade_s), ms.grade);
        check_val({tag, "_s_valid"}, int'(valid_s), (ms.left > 0) ? 1 : 0);
    endtask

    task automatic step(input string tag, input bit rst, input logic [3:0] j, input bit m, input bit f);
        @(negedge clk);
        reset_i = rst;
        judge_i = j;
        miss_i  = m;
        frame_i = f;
        @(posedge clk);
        if (rst) begin
            mw = '{0, 0, 0, 0, 0};
            ms = '{0, 0, 0, 0, 0};
        end else begin
            mw = model_step(mw, j, m, f, 65535, 255);
            ms = model_step(ms, j, m, f, 63, 7);
        end
        #1;
        compare_all(tag);
        reset_i = 1'b0;
        judge_i = 4'd0;
        miss_i  = 1'b0;
        frame_i = 1'b0;
    endtask

    initial begin
        // reset state
        step("rst", 1'b1, 4'd0, 1'b0, 1'b0);
        check_val("rst_score_const", int'(score_w), 0);
        check_val("rst_valid_const", int'(valid_w), 0);

        // single marvelous
        step("t1", 1'b0, 4'b1000, 1'b0, 1'b0);
        check_val("t1_score_const", int'(score_w), 10);
        check_val("t1_grade_const", int'(grade_w), 4);
        check_val("t1_valid_const", int'(valid_w), 1);

        // combo bonus on the 10th good, then a miss
        step("rst", 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("t2", 1'b0, 4'b0001, 1'b0, 1'b0);
        check_val("t2_score_const", int'(score_w), 22);
        check_val("t2_combo_const", int'(combo_w), 10);
        step("t2m", 1'b0, 4'd0, 1'b1, 1'b0);
        check_val("t2_miss_combo", int'(combo_w), 0);
        check_val("t2_miss_max", int'(max_w), 10);
        check_val("t2_miss_grade", int'(grade_w), 5);

        // multi-bit judge with simultaneous miss
        step("rst", 1'b1, 4'd0, 1'b0, 1'b0);
        step("t3", 1'b0, 4'b0101, 1'b1, 1'b0);
        check_val("t3_score_const", int'(score_w), 8);
        check_val("t3_grade_const", int'(grade_w), 3);
        check_val("t3_combo_const", int'(combo_w), 0);
        check_val("t3_max_const", int'(max_w), 1);

        // hold timing and reload on the 29th frame
        step("rst", 1'b1, 4'd0, 1'b0, 1'b0);
        step("t4", 1'b0, 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 29; i++) step("t4f", 1'b0, 4'd0, 1'b0, 1'b1);
        check_val("t4_valid29", int'(valid_w), 1);
        step("t4f30", 1'b0, 4'd0, 1'b0, 1'b1);
        check_val("t4_valid30", int'(valid_w), 0);
        check_val("t4_grade30", int'(grade_w), 0);
        step("t4b", 1'b0, 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 28; i++) step("t4bf", 1'b0, 4'd0, 1'b0, 1'b1);
        step("t4breload", 1'b0, 4'b0100, 1'b0, 1'b1);
        check_val("t4_reload_valid", int'(valid_w), 1);
        for (int i = 0; i < 29; i++) step("t4cf", 1'b0, 4'd0, 1'b0, 1'b1);
        check_val("t4_after_reload29", int'(valid_w), 1);
        step("t4cf30", 1'b0, 4'd0, 1'b0, 1'b1);
        check_val("t4_after_reload30", int'(valid_w), 0);

        // saturation on the narrow instance
        step("rst", 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step("t5", 1'b0, 4'b1000, 1'b0, 1'b0);
        check_val("t5_small_score", int'(score_s), 63);
        check_val("t5_small_combo", int'(combo_s), 7);
        check_val("t5_small_max", int'(max_s), 7);
        check_val("t5_wide_score", int'(score_w), 90);

        // reset during SHOW
        step("t6hit", 1'b0, 4'b1000, 1'b0, 1'b0);
        step("t6rst", 1'b1, 4'd0, 1'b0, 1'b1);
        check_val("t6_score", int'(score_w), 0);
        check_val("t6_valid", int'(valid_w), 0);
        check_val("t6_grade", int'(grade_w), 0);

        // random traffic: alternate busy and sparse phases so both saturation and expiry occur
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] j;
            bit m, f, r;
            int ev_div;
            ev_div = ((i / 500) % 2 == 0) ? 3 : 40;
            j = ($urandom_range(0, ev_div - 1) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            m = ($urandom_range(0, 7) == 0);
            f = ($urandom_range(0, 1) == 0);
            r = ($urandom_range(0, 999) == 0);
            step("rnd", r, j, m, f);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
